// File: rtl/inst_prefetch_queue_if.sv
// Fetch-side bus bundle: instruction memory port, execute redirect and decode handshake.
interface inst_prefetch_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_inst;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, count,
    input  imem_ack, imem_inst, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, count,
    output imem_ack, imem_inst, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetcher: one outstanding sequential fetch into a DEPTH-entry
// {pc, inst} queue feeding decode; a redirect flushes the queue and restarts fetch.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_START = 32'h0100_0000
) (
  input logic                   clock,
  input logic                   reset,
  inst_prefetch_queue_if.master bus
);
  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [31:0]     NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        r_state;
  logic          r_imemReq;
  logic [31:0]   r_imemAddr;
  logic [31:0]   r_fetchPc;
  logic [31:0]   r_memPc   [DEPTH];
  logic [31:0]   r_memInst [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_countAfterPop;
  logic [CW-1:0] w_countAfterPush;
  logic [31:0]   w_redirectPc;
  logic [31:0]   w_nextFetchPc;

  // A redirect cancels both the pop and the push of its cycle.
  assign w_valid          = (r_count != '0);
  assign w_pop            = w_valid & bus.inst_ready & ~bus.redirect;
  assign w_push           = (r_state == WAIT) & bus.imem_ack & ~bus.redirect;
  assign w_countAfterPop  = r_count - CW'(w_valid & bus.inst_ready);
  assign w_countAfterPush = w_countAfterPop + CW'(1);
  assign w_redirectPc     = bus.redirect_pc & 32'hffff_fffe;
  assign w_nextFetchPc    = r_fetchPc + 32'd4;

  // Head is read straight from registered storage, so decode never sees imem combinationally.
  assign bus.inst_valid = w_valid;
  assign bus.inst       = w_valid ? r_memInst[r_rdPtr] : NOP;
  assign bus.inst_pc    = w_valid ? r_memPc[r_rdPtr] : 32'h0;
  assign bus.count      = r_count;
  assign bus.imem_req   = r_imemReq;
  assign bus.imem_addr  = r_imemAddr;

  // Fetch FSM: issues requests only when a queue slot is guaranteed, drops responses after a redirect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_imemReq  <= 1'b0;
      r_imemAddr <= PC_START;
      r_fetchPc  <= PC_START;
    end else if (bus.redirect) begin
      r_fetchPc <= w_redirectPc;
      case (r_state)
        IDLE: begin
          r_state    <= WAIT;
          r_imemReq  <= 1'b1;
          r_imemAddr <= w_redirectPc;
        end
        WAIT: begin
          if (bus.imem_ack) begin
            r_imemAddr <= w_redirectPc;
          end else begin
            r_state <= DISCARD;
          end
        end
        default: r_state <= DISCARD;
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (w_countAfterPop < FULL) begin
            r_state    <= WAIT;
            r_imemReq  <= 1'b1;
            r_imemAddr <= r_fetchPc;
          end
        end
        WAIT: begin
          if (bus.imem_ack) begin
            r_fetchPc <= w_nextFetchPc;
            if (w_countAfterPush < FULL) begin
              r_imemAddr <= w_nextFetchPc;
            end else begin
              r_state   <= IDLE;
              r_imemReq <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (bus.imem_ack) begin
            r_state    <= WAIT;
            r_imemAddr <= r_fetchPc;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_imemReq <= 1'b0;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (bus.redirect) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Entry storage; a push into a full queue without a matching pop would lose data.
  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!(w_push && !w_pop && (r_count == FULL)));
    end
    if (w_push) begin
      r_memPc[r_wrPtr]   <= r_fetchPc;
      r_memInst[r_wrPtr] <= bus.imem_inst;
    end
  end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed scenarios then randomized traffic, all
// compared each cycle against a queue-based model of the prefetcher.
module tb_inst_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] PC_START = 32'h0100_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  inst_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  inst_prefetch_queue #(.DEPTH(DEPTH), .PC_START(PC_START)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  int          vecCount  = 0;
  int          missCount = 0;
  entry_t      mQueue[$];
  bit          mReqOut;
  bit          mDropResp;
  logic [31:0] mReqAddr;
  logic [31:0] mFetchPc;
  int          respAge;
  int          respDelay;
  bit          respRandom;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h5a5a_c3c3;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] expInst;
    logic [31:0] expPc;
    expInst = NOP;
    expPc   = 32'h0;
    if (mQueue.size() != 0) begin
      expInst = mQueue[0].word;
      expPc   = mQueue[0].pc;
    end
    checkValue("inst_valid", 32'(bus.inst_valid), 32'(mQueue.size() != 0));
    checkValue("inst", bus.inst, expInst);
    checkValue("inst_pc", bus.inst_pc, expPc);
    checkValue("count", 32'(bus.count), 32'(mQueue.size()));
    checkValue("imem_req", 32'(bus.imem_req), 32'(mReqOut));
    if (mReqOut) checkValue("imem_addr", bus.imem_addr, mReqAddr);
  endtask

  // Model: one request in flight at most, its response possibly marked for dropping.
  function automatic void modelStep(input bit ack, input logic [31:0] data, input bit redir,
                                    input logic [31:0] rpc, input bit ready);
    entry_t e;
    if (redir) begin
      mQueue.delete();
      mFetchPc = rpc & 32'hffff_fffe;
      if (mReqOut && (mDropResp || !ack)) begin
        mDropResp = 1'b1;
      end else begin
        mReqOut   = 1'b1;
        mReqAddr  = mFetchPc;
        mDropResp = 1'b0;
      end
    end else begin
      if (ready && mQueue.size() != 0) void'(mQueue.pop_front());
      if (mReqOut && ack) begin
        if (mDropResp) begin
          mDropResp = 1'b0;
          mReqAddr  = mFetchPc;
        end else begin
          e.pc   = mFetchPc;
          e.word = data;
          mQueue.push_back(e);
          mFetchPc = mFetchPc + 32'd4;
          if (mQueue.size() < DEPTH) mReqAddr = mFetchPc;
          else mReqOut = 1'b0;
        end
      end else if (!mReqOut && mQueue.size() < DEPTH) begin
        mReqOut  = 1'b1;
        mReqAddr = mFetchPc;
      end
    end
  endfunction

  task automatic applyStimulus(input bit ack, input logic [31:0] data, input bit redir,
                               input logic [31:0] rpc, input bit ready);
    bus.imem_ack    = ack;
    bus.imem_inst   = data;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.inst_ready  = ready;
    modelStep(ack, data, redir, rpc, ready);
    @(negedge clock);
    checkOutput();
  endtask

  // One cycle with the memory responder acking respDelay cycles after a request appears.
  task automatic step(input bit ready, input bit redir, input logic [31:0] rpc);
    bit ack;
    ack = 1'b0;
    if (mReqOut) begin
      if (respAge >= respDelay) begin
        ack     = 1'b1;
        respAge = 0;
        if (respRandom) respDelay = $urandom_range(0, 3);
      end else begin
        respAge++;
      end
    end
    applyStimulus(ack, memWord(mReqAddr), redir, rpc, ready);
  endtask

  task automatic doReset();
    reset           = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_inst   = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.inst_ready  = 1'b0;
    mQueue.delete();
    mReqOut   = 1'b0;
    mDropResp = 1'b0;
    mReqAddr  = PC_START;
    mFetchPc  = PC_START;
    respAge   = 0;
    #1;
    checkValue("rst_imem_req", 32'(bus.imem_req), 32'h0);
    checkValue("rst_imem_addr", bus.imem_addr, PC_START);
    checkValue("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    checkValue("rst_inst", bus.inst, NOP);
    checkValue("rst_inst_pc", bus.inst_pc, 32'h0);
    checkValue("rst_count", 32'(bus.count), 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    respRandom = 1'b0;
    respDelay  = 0;
    @(negedge clock);

    $display("[TB] reset and sequential fetch, ack two cycles after each request");
    doReset();
    respDelay = 2;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    checkValue("first_valid", 32'(bus.inst_valid), 32'h1);
    checkValue("first_pc", bus.inst_pc, 32'h0100_0000);
    checkValue("second_addr", bus.imem_addr, 32'h0100_0004);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0);

    $display("[TB] fill with decode stalled, then a single pop");
    doReset();
    respDelay = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
    checkValue("fill_count", 32'(bus.count), 32'(DEPTH));
    checkValue("fill_req", 32'(bus.imem_req), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    checkValue("pop_count", 32'(bus.count), 32'(DEPTH - 1));
    checkValue("refill_req", 32'(bus.imem_req), 32'h1);
    checkValue("refill_addr", bus.imem_addr, 32'h0100_0010);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);

    $display("[TB] redirect while a request is outstanding");
    doReset();
    respDelay = 2;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0100_0101);
    checkValue("disc_count", 32'(bus.count), 32'h0);
    checkValue("disc_addr", bus.imem_addr, 32'h0100_0000);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    checkValue("redir_addr", bus.imem_addr, 32'h0100_0100);
    checkValue("redir_empty", 32'(bus.inst_valid), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    checkValue("redir_head_pc", bus.inst_pc, 32'h0100_0100);

    $display("[TB] redirect together with ack and pop");
    doReset();
    respDelay = 0;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0200_0000);
    checkValue("same_count", 32'(bus.count), 32'h0);
    checkValue("same_addr", bus.imem_addr, 32'h0200_0000);
    step(1'b0, 1'b0, 32'h0);
    checkValue("same_head_pc", bus.inst_pc, 32'h0200_0000);

    $display("[TB] reset during an outstanding request, stale ack afterwards");
    doReset();
    respDelay = 3;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    doReset();
    applyStimulus(1'b1, 32'hdead_beef, 1'b0, 32'h0, 1'b1);
    checkValue("stale_count", 32'(bus.count), 32'h0);
    checkValue("stale_addr", bus.imem_addr, 32'h0100_0000);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

    $display("[TB] randomized traffic");
    doReset();
    respRandom = 1'b1;
    respDelay  = $urandom_range(0, 3);
    for (int i = 0; i < 600; i++) begin
      bit          ready;
      bit          redir;
      logic [31:0] rpc;
      ready = (i < 300) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = ($urandom_range(0, 2) == 0) ? 32'hffff_fff5 : $urandom();
      step(ready, redir, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
